bus_datapath_mc: RTL and testbench

//  Parametrised single-bus CPU datapath core: NREGS x WIDTH register file, Y latch, 2*WIDTH Z register.
//  Bus source select is one-hot with conflict detection.
//  ALU runs logic/add/shift ops in one cycle and MUL/DIV iteratively behind a start/busy/done handshake.

---
 rtl/dp_pkg.sv | 29 ++
 rtl/mul_div_iter.sv | 145 ++++++++++++++
 rtl/bus_datapath_mc.sv | 183 ++++++++++++++++++
 tb/tb_bus_datapath_mc.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_pkg.sv
// Shared definitions for the single-bus datapath: ALU opcodes, iterative-engine
// FSM encodings and the shift-amount width helper.
package dp_pkg;

    // ADD/SUB/NEG/SHRA fill Zhi with the sign of the result; all other
    // single-cycle ops fill Zhi with zeros.
    localparam logic [4:0] OP_ADD  = 5'h00;
    localparam logic [4:0] OP_SUB  = 5'h01;
    localparam logic [4:0] OP_AND  = 5'h02;
    localparam logic [4:0] OP_OR   = 5'h03;
    localparam logic [4:0] OP_NOT  = 5'h04;
    localparam logic [4:0] OP_NEG  = 5'h05;
    localparam logic [4:0] OP_SHL  = 5'h06;
    localparam logic [4:0] OP_SHR  = 5'h07;
    localparam logic [4:0] OP_SHRA = 5'h08;
    localparam logic [4:0] OP_ROL  = 5'h09;
    localparam logic [4:0] OP_ROR  = 5'h0A;
    localparam logic [4:0] OP_MUL  = 5'h0B;
    localparam logic [4:0] OP_DIV  = 5'h0C;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ITER = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    function automatic int shamt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/mul_div_iter.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring on magnitudes).
// start is honoured only in IDLE; done marks the FIX cycle, when hi/lo/div0 are final.
module mul_div_iter
    import dp_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div0,
    output logic [1:0]       state
);
    localparam int CW = shamt_w(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic             qm1_q, qm1_d;
    logic             is_div_q, is_div_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             div0_q, div0_d;

    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH+1:0] trial;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        m_d      = m_q;
        qm1_d    = qm1_q;
        is_div_d = is_div_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        div0_d   = div0_q;

        // acc is one bit wider than the operand so subtracting the most negative
        // multiplicand cannot overflow.
        case ({lo_q[0], qm1_q})
            2'b01:   booth_sum = acc_q + {m_q[WIDTH-1], m_q};
            2'b10:   booth_sum = acc_q - {m_q[WIDTH-1], m_q};
            default: booth_sum = acc_q;
        endcase
        rem_shift = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
        trial     = {1'b0, rem_shift} - {2'b00, m_q};

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_ITER;
                    cnt_d    = '0;
                    acc_d    = '0;
                    qm1_d    = 1'b0;
                    is_div_d = is_div;
                    if (is_div) begin
                        lo_d   = a[WIDTH-1] ? -a : a;
                        m_d    = b[WIDTH-1] ? -b : b;
                        negq_d = a[WIDTH-1] ^ b[WIDTH-1];
                        negr_d = a[WIDTH-1];
                        div0_d = (b == '0);
                    end else begin
                        lo_d   = b;
                        m_d    = a;
                        negq_d = 1'b0;
                        negr_d = 1'b0;
                        div0_d = 1'b0;
                    end
                end
            end
            ST_ITER: begin
                if (is_div_q) begin
                    acc_d = trial[WIDTH+1] ? rem_shift : trial[WIDTH:0];
                    lo_d  = {lo_q[WIDTH-2:0], ~trial[WIDTH+1]};
                end else begin
                    acc_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                    lo_d  = {booth_sum[0], lo_q[WIDTH-1:1]};
                    qm1_d = lo_q[0];
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            m_q      <= '0;
            qm1_q    <= 1'b0;
            is_div_q <= 1'b0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            m_q      <= m_d;
            qm1_q    <= qm1_d;
            is_div_q <= is_div_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            div0_q   <= div0_d;
        end
    end

    // With a zero divisor the restoring loop leaves |A| as remainder, so the
    // sign fix already yields Zhi = A; only the quotient needs forcing.
    always_comb begin
        if (is_div_q) begin
            hi = negr_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            lo = div0_q ? '1 : (negq_q ? -lo_q : lo_q);
        end else begin
            hi = acc_q[WIDTH-1:0];
            lo = lo_q;
        end
    end

    assign busy  = (state_q != ST_IDLE);
    assign done  = (state_q == ST_FIX);
    assign div0  = div0_q;
    assign state = state_q;

endmodule

// File: rtl/bus_datapath_mc.sv
// Single-bus CPU datapath: priority bus mux with conflict flag, register file,
// Y latch, 2*WIDTH Z register, one-cycle ALU and the iterative MUL/DIV engine.
module bus_datapath_mc
    import dp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREGS = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [NREGS-1:0] reg_in,
    input  logic [NREGS-1:0] reg_out,
    input  logic             ba_out,
    input  logic             y_in,
    input  logic             zhi_out,
    input  logic             zlo_out,
    input  logic             ext_out,
    input  logic [WIDTH-1:0] ext_in,
    input  logic [4:0]       opcode,
    input  logic             alu_start,
    output logic [WIDTH-1:0] bus,
    output logic             bus_conflict,
    output logic             alu_busy,
    output logic             alu_done,
    output logic             div_by_zero,
    output logic             illegal_op
);
    localparam int SW = shamt_w(WIDTH);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] zhi_q, zhi_d;
    logic [WIDTH-1:0] zlo_q, zlo_d;
    logic             pend_q, pend_d;
    logic             pend_div0_q, pend_div0_d;
    logic             pend_ill_q, pend_ill_d;
    logic             alu_done_q, div_by_zero_q, illegal_op_q;

    logic [WIDTH-1:0] bus_val;
    logic             src_found;
    logic [NREGS+2:0] src_vec;

    logic [WIDTH-1:0]   sc_res;
    logic               sc_valid;
    logic               sc_sext;
    logic [2*WIDTH-1:0] rol_full;
    logic [2*WIDTH-1:0] ror_full;
    logic [SW-1:0]      sh;
    logic               is_md;

    logic             eng_start, eng_busy, eng_done, eng_div0;
    logic [WIDTH-1:0] eng_hi, eng_lo;
    logic [1:0]       eng_state;

    always_comb begin
        bus_val   = '0;
        src_found = 1'b0;
        for (int k = 0; k < NREGS; k++) begin
            if (reg_out[k] && !src_found) begin
                src_found = 1'b1;
                bus_val   = (k == 0 && ba_out) ? '0 : regs_q[k];
            end
        end
        if (!src_found) begin
            if (zhi_out)      bus_val = zhi_q;
            else if (zlo_out) bus_val = zlo_q;
            else if (ext_out) bus_val = ext_in;
        end
    end

    // Clearing the lowest set bit leaves something only if two or more sources drive.
    assign src_vec      = {ext_out, zlo_out, zhi_out, reg_out};
    assign bus_conflict = |(src_vec & (src_vec - 1'b1));
    assign bus          = bus_val;

    always_comb begin
        sh       = bus_val[SW-1:0];
        rol_full = {y_q, y_q} << sh;
        ror_full = {y_q, y_q} >> sh;
        sc_res   = '0;
        sc_valid = 1'b1;
        sc_sext  = 1'b0;
        case (opcode)
            OP_ADD:  begin sc_res = y_q + bus_val; sc_sext = 1'b1; end
            OP_SUB:  begin sc_res = y_q - bus_val; sc_sext = 1'b1; end
            OP_AND:  sc_res = y_q & bus_val;
            OP_OR:   sc_res = y_q | bus_val;
            OP_NOT:  sc_res = ~bus_val;
            OP_NEG:  begin sc_res = -bus_val; sc_sext = 1'b1; end
            OP_SHL:  sc_res = y_q << sh;
            OP_SHR:  sc_res = y_q >> sh;
            OP_SHRA: begin sc_res = $signed(y_q) >>> sh; sc_sext = 1'b1; end
            OP_ROL:  sc_res = rol_full[2*WIDTH-1:WIDTH];
            OP_ROR:  sc_res = ror_full[WIDTH-1:0];
            default: sc_valid = 1'b0;
        endcase
    end

    assign is_md     = (opcode == OP_MUL) || (opcode == OP_DIV);
    assign eng_start = alu_start && !eng_busy && is_md;

    mul_div_iter #(
        .WIDTH(WIDTH)
    ) u_mul_div (
        .clk    (clk),
        .clr    (clr),
        .start  (eng_start),
        .is_div (opcode == OP_DIV),
        .a      (y_q),
        .b      (bus_val),
        .busy   (eng_busy),
        .done   (eng_done),
        .hi     (eng_hi),
        .lo     (eng_lo),
        .div0   (eng_div0),
        .state  (eng_state)
    );

    always_comb begin
        regs_d = regs_q;
        for (int k = 0; k < NREGS; k++) begin
            if (reg_in[k]) regs_d[k] = bus_val;
        end
        y_d = y_in ? bus_val : y_q;

        zhi_d       = zhi_q;
        zlo_d       = zlo_q;
        pend_d      = 1'b0;
        pend_div0_d = 1'b0;
        pend_ill_d  = 1'b0;
        // Z updates on its own edge; the done/flag pulse follows one edge later.
        if (eng_done) begin
            zhi_d       = eng_hi;
            zlo_d       = eng_lo;
            pend_d      = 1'b1;
            pend_div0_d = eng_div0;
        end else if (alu_start && !eng_busy) begin
            if (sc_valid) begin
                zlo_d  = sc_res;
                zhi_d  = sc_sext ? {WIDTH{sc_res[WIDTH-1]}} : '0;
                pend_d = 1'b1;
            end else if (!is_md) begin
                pend_d     = 1'b1;
                pend_ill_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int k = 0; k < NREGS; k++) regs_q[k] <= '0;
            y_q           <= '0;
            zhi_q         <= '0;
            zlo_q         <= '0;
            pend_q        <= 1'b0;
            pend_div0_q   <= 1'b0;
            pend_ill_q    <= 1'b0;
            alu_done_q    <= 1'b0;
            div_by_zero_q <= 1'b0;
            illegal_op_q  <= 1'b0;
        end else begin
            regs_q        <= regs_d;
            y_q           <= y_d;
            zhi_q         <= zhi_d;
            zlo_q         <= zlo_d;
            pend_q        <= pend_d;
            pend_div0_q   <= pend_div0_d;
            pend_ill_q    <= pend_ill_d;
            alu_done_q    <= pend_q;
            div_by_zero_q <= pend_div0_q;
            illegal_op_q  <= pend_ill_q;
        end
    end

    assign alu_busy    = eng_busy;
    assign alu_done    = alu_done_q;
    assign div_by_zero = div_by_zero_q;
    assign illegal_op  = illegal_op_q;

    assert property (@(posedge clk) disable iff (!clr) eng_busy == (eng_state != ST_IDLE));

endmodule

// File: tb/tb_bus_datapath_mc.sv
// Self-checking bench for bus_datapath_mc (WIDTH=32, NREGS=16): bus/register
// behaviour, single-cycle and iterative ALU ops, illegal opcodes and mid-op reset.
module tb_bus_datapath_mc;
    import dp_pkg::*;

    localparam int W  = 32;
    localparam int NR = 16;

    logic          clk = 1'b0;
    logic          clr;
    logic [NR-1:0] reg_in, reg_out;
    logic          ba_out, y_in, zhi_out, zlo_out, ext_out;
    logic [W-1:0]  ext_in;
    logic [4:0]    opcode;
    logic          alu_start;
    logic [W-1:0]  bus;
    logic          bus_conflict, alu_busy, alu_done, div_by_zero, illegal_op;

    int checks = 0;
    int errors = 0;
    logic [2*W+1:0] exp_q[$];
    logic [2*W-1:0] z_model;

    bus_datapath_mc #(.WIDTH(W), .NREGS(NR)) dut (
        .clk(clk), .clr(clr), .reg_in(reg_in), .reg_out(reg_out), .ba_out(ba_out),
        .y_in(y_in), .zhi_out(zhi_out), .zlo_out(zlo_out), .ext_out(ext_out),
        .ext_in(ext_in), .opcode(opcode), .alu_start(alu_start), .bus(bus),
        .bus_conflict(bus_conflict), .alu_busy(alu_busy), .alu_done(alu_done),
        .div_by_zero(div_by_zero), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- driver tasks (all begin and end just after a negedge)
    task automatic idle_inputs();
        reg_in = '0; reg_out = '0; ba_out = 1'b0; y_in = 1'b0;
        zhi_out = 1'b0; zlo_out = 1'b0; ext_out = 1'b0; ext_in = '0;
        opcode = OP_ADD; alu_start = 1'b0;
    endtask

    task automatic write_reg(input int k, input logic [W-1:0] val);
        ext_in = val; ext_out = 1'b1; reg_in = '0; reg_in[k] = 1'b1;
        @(posedge clk); @(negedge clk);
        ext_out = 1'b0; reg_in = '0;
    endtask

    task automatic load_y(input logic [W-1:0] val);
        ext_in = val; ext_out = 1'b1; y_in = 1'b1;
        @(posedge clk); @(negedge clk);
        ext_out = 1'b0; y_in = 1'b0;
    endtask

    task automatic start_op(input logic [4:0] op, input logic [W-1:0] bval, input logic [2*W+1:0] expv);
        exp_q.push_back(expv);
        z_model = expv[2*W-1:0];
        ext_in = bval; ext_out = 1'b1; opcode = op; alu_start = 1'b1;
        @(posedge clk); @(negedge clk);
        ext_out = 1'b0; alu_start = 1'b0;
    endtask

    task automatic read_z(output logic [2*W-1:0] z);
        zhi_out = 1'b1; #1 z[2*W-1:W] = bus;
        zhi_out = 1'b0; zlo_out = 1'b1; #1 z[W-1:0] = bus;
        zlo_out = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n, output bit ok, output bit busy_seen);
        n = 0; ok = 1'b0; busy_seen = 1'b0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (alu_busy) busy_seen = 1'b1;
            if (alu_done) begin
                n = i; ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- reference model: {illegal, div0, Zhi, Zlo}
    function automatic logic [2*W+1:0] model(input logic [4:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic [2*W-1:0] zprev);
        logic [W-1:0] lo;
        logic signed [W-1:0] sa, sb, q, r;
        logic signed [2*W-1:0] pa, pb, p;
        logic [2*W-1:0] z;
        logic ill, d0;
        int s;
        sa = a; sb = b; pa = sa; pb = sb;
        s = int'(b % W);
        ill = 1'b0; d0 = 1'b0; z = zprev; lo = '0;
        case (op)
            OP_ADD:  begin lo = a + b; z = {{W{lo[W-1]}}, lo}; end
            OP_SUB:  begin lo = a - b; z = {{W{lo[W-1]}}, lo}; end
            OP_AND:  z = {{W{1'b0}}, a & b};
            OP_SHL:  z = {{W{1'b0}}, a << s};
            OP_SHRA: begin lo = sa >>> s; z = {{W{lo[W-1]}}, lo}; end
            OP_ROL:  begin lo = a; repeat (s) lo = {lo[W-2:0], lo[W-1]}; z = {{W{1'b0}}, lo}; end
            OP_ROR:  begin lo = a; repeat (s) lo = {lo[0], lo[W-1:1]}; z = {{W{1'b0}}, lo}; end
            OP_MUL:  begin p = pa * pb; z = p; end
            OP_DIV:  begin
                if (b == '0) begin
                    d0 = 1'b1; z = {a, {W{1'b1}}};
                end else begin
                    q = sa / sb; r = sa % sb; z = {r, q};
                end
            end
            default: ill = 1'b1;
        endcase
        return {ill, d0, z};
    endfunction

    // ---------------- scoreboard: pop and compare on alu_done
    task automatic sb_check(input string name, input int lat_exp, input int n, input bit ok);
        logic [2*W+1:0] e;
        logic [2*W-1:0] z;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: alu_done never seen within cycle budget", name);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: alu_done with empty expected queue", name);
            return;
        end
        e = exp_q.pop_front();
        if (n !== lat_exp) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles, expected %0d", name, n, lat_exp);
        end
        checks++;
        if ({illegal_op, div_by_zero} !== e[2*W+1:2*W]) begin
            errors++;
            $display("FAIL %s flags: got ill=%b div0=%b, expected ill=%b div0=%b",
                     name, illegal_op, div_by_zero, e[2*W+1], e[2*W]);
        end
        checks++;
        read_z(z);
        if (z !== e[2*W-1:0]) begin
            errors++;
            $display("FAIL %s Z: got %h, expected %h", name, z, e[2*W-1:0]);
        end
    endtask

    // ---------------- scenarios
    task automatic test_reset();
        logic [2*W-1:0] z;
        clr = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        checks++;
        if ({alu_busy, alu_done, div_by_zero, illegal_op} !== 4'b0000) begin
            errors++;
            $display("FAIL reset status: got busy/done/div0/ill=%b, expected 0000",
                     {alu_busy, alu_done, div_by_zero, illegal_op});
        end
        checks++;
        if (bus !== '0 || bus_conflict !== 1'b0) begin
            errors++;
            $display("FAIL reset bus idle: got bus=%h conflict=%b, expected 0/0", bus, bus_conflict);
        end
        reg_out[7] = 1'b1; #1;
        checks++;
        if (bus !== '0) begin
            errors++;
            $display("FAIL reset R7: got %h, expected 0", bus);
        end
        reg_out = '0;
        read_z(z);
        checks++;
        if (z !== '0) begin
            errors++;
            $display("FAIL reset Z: got %h, expected 0", z);
        end
        z_model = '0;
    endtask

    task automatic test_bus_regs();
        write_reg(0, 32'hAAAA5555);
        write_reg(3, 32'hDEADBEEF);
        write_reg(5, 32'h12345678);
        reg_out = '0; reg_out[3] = 1'b1; #1;
        checks++;
        if (bus !== 32'hDEADBEEF || bus_conflict !== 1'b0) begin
            errors++;
            $display("FAIL R3 read: got bus=%h conflict=%b, expected deadbeef/0", bus, bus_conflict);
        end
        reg_out[5] = 1'b1; #1;
        checks++;
        if (bus !== 32'hDEADBEEF || bus_conflict !== 1'b1) begin
            errors++;
            $display("FAIL R3+R5 conflict: got bus=%h conflict=%b, expected deadbeef/1", bus, bus_conflict);
        end
        reg_out = '0; reg_out[0] = 1'b1; #1;
        checks++;
        if (bus !== 32'hAAAA5555) begin
            errors++;
            $display("FAIL R0 read: got %h, expected aaaa5555", bus);
        end
        ba_out = 1'b1; #1;
        checks++;
        if (bus !== '0 || bus_conflict !== 1'b0) begin
            errors++;
            $display("FAIL R0 ba_out: got bus=%h conflict=%b, expected 0/0", bus, bus_conflict);
        end
        reg_out = '0; ba_out = 1'b0;
        ext_in = 32'h55667788; ext_out = 1'b1; zlo_out = 1'b1; #1;
        checks++;
        if (bus !== '0 || bus_conflict !== 1'b1) begin
            errors++;
            $display("FAIL zlo over ext: got bus=%h conflict=%b, expected 0/1", bus, bus_conflict);
        end
        zlo_out = 1'b0;
        ext_in = 32'h0F0F0F0F; reg_in = '0; reg_in[7] = 1'b1; reg_in[9] = 1'b1;
        @(posedge clk); @(negedge clk);
        reg_in = '0; ext_out = 1'b0;
        reg_out[9] = 1'b1; #1;
        checks++;
        if (bus !== 32'h0F0F0F0F) begin
            errors++;
            $display("FAIL multi-write R9: got %h, expected 0f0f0f0f", bus);
        end
        reg_out = '0; reg_out[7] = 1'b1; #1;
        checks++;
        if (bus !== 32'h0F0F0F0F) begin
            errors++;
            $display("FAIL multi-write R7: got %h, expected 0f0f0f0f", bus);
        end
        reg_out = '0;
    endtask

    task automatic test_add();
        int n; bit ok, busy_seen;
        load_y(32'h7FFFFFFF);
        start_op(OP_ADD, 32'h1, {2'b00, 32'hFFFFFFFF, 32'h80000000});
        checks++;
        if (alu_busy !== 1'b0) begin
            errors++;
            $display("FAIL add busy after start: got %b, expected 0", alu_busy);
        end
        wait_done(10, n, ok, busy_seen);
        checks++;
        if (busy_seen) begin
            errors++;
            $display("FAIL add busy: got busy=1 during single-cycle op, expected 0");
        end
        sb_check("add", 1, n, ok);
        @(negedge clk);
        checks++;
        if (alu_done !== 1'b0) begin
            errors++;
            $display("FAIL add done pulse width: got done=%b one cycle later, expected 0", alu_done);
        end
    endtask

    task automatic test_mul();
        int n; bit ok;
        load_y(-32'sd3);
        start_op(OP_MUL, 32'd7, {2'b00, 64'hFFFFFFFF_FFFFFFEB});
        ok = 1'b0; n = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            alu_start = 1'b0; ext_out = 1'b0; opcode = OP_MUL;
            if (alu_done) begin
                n = i; ok = 1'b1;
                break;
            end
            if (i == 5) begin
                checks++;
                if (alu_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL mul busy mid-op: got %b, expected 1", alu_busy);
                end
                ext_in = 32'd100; ext_out = 1'b1; opcode = OP_ADD; alu_start = 1'b1;
            end
        end
        sb_check("mul", 34, n, ok);
        ok = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (alu_done) ok = 1'b1;
        end
        checks++;
        if (ok || exp_q.size() != 0) begin
            errors++;
            $display("FAIL mul ignored start: got extra done=%b queue=%0d, expected 0/0", ok, exp_q.size());
        end
    endtask

    task automatic test_div();
        int n; bit ok, busy_seen;
        load_y(-32'sd17);
        start_op(OP_DIV, 32'd5, {2'b00, 32'hFFFFFFFE, 32'hFFFFFFFD});
        wait_done(60, n, ok, busy_seen);
        sb_check("div", 34, n, ok);
        load_y(32'd9);
        start_op(OP_DIV, 32'd0, {2'b01, 32'h00000009, 32'hFFFFFFFF});
        wait_done(60, n, ok, busy_seen);
        sb_check("div0", 34, n, ok);
    endtask

    task automatic test_ror_illegal();
        int n; bit ok, busy_seen;
        load_y(32'h00000001);
        start_op(OP_ROR, 32'd33, {2'b00, 32'h00000000, 32'h80000000});
        wait_done(10, n, ok, busy_seen);
        sb_check("ror", 1, n, ok);
        load_y(32'h12345678);
        start_op(5'h1F, 32'h00FF00FF, {2'b10, z_model});
        wait_done(10, n, ok, busy_seen);
        sb_check("illegal", 1, n, ok);
    endtask

    task automatic test_clr_abort();
        int n; bit ok, busy_seen;
        logic [2*W-1:0] z;
        load_y(-32'sd3);
        start_op(OP_MUL, 32'd7, {2'b00, 64'hFFFFFFFF_FFFFFFEB});
        repeat (10) @(negedge clk);
        checks++;
        if (alu_busy !== 1'b1) begin
            errors++;
            $display("FAIL abort pre-busy: got %b, expected 1", alu_busy);
        end
        #1 clr = 1'b0;
        #1;
        checks++;
        if (alu_busy !== 1'b0 || alu_done !== 1'b0) begin
            errors++;
            $display("FAIL abort async: got busy=%b done=%b, expected 0/0", alu_busy, alu_done);
        end
        @(negedge clk);
        clr = 1'b1;
        void'(exp_q.pop_back());
        z_model = '0;
        read_z(z);
        checks++;
        if (z !== '0) begin
            errors++;
            $display("FAIL abort Z: got %h, expected 0", z);
        end
        wait_done(40, n, ok, busy_seen);
        checks++;
        if (ok || busy_seen) begin
            errors++;
            $display("FAIL abort no done: got done=%b busy=%b after clr, expected 0/0", ok, busy_seen);
        end
        load_y(32'd5);
        start_op(OP_ADD, 32'd6, {2'b00, 32'h0, 32'd11});
        wait_done(10, n, ok, busy_seen);
        sb_check("add after abort", 1, n, ok);
    endtask

    task automatic test_back_to_back();
        logic [4:0] ops [7] = '{OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_SHRA, OP_ROL};
        logic [4:0] op;
        logic [W-1:0] a, b;
        int n; bit ok, busy_seen;
        for (int t = 0; t < 10; t++) begin
            op = ops[$urandom_range(0, 6)];
            a  = $urandom;
            b  = $urandom;
            if (op == OP_SHRA || op == OP_ROL) b = $urandom_range(0, 63);
            if (op == OP_DIV && (b == '0 || (a == 32'h80000000 && b == '1))) b = 32'd7;
            load_y(a);
            start_op(op, b, model(op, a, b, z_model));
            wait_done(60, n, ok, busy_seen);
            sb_check("rand", (op == OP_MUL || op == OP_DIV) ? 34 : 1, n, ok);
        end
    endtask

    initial begin
        test_reset();
        test_bus_regs();
        test_add();
        test_mul();
        test_div();
        test_ror_illegal();
        test_clr_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
